wbu_commit_queue: RTL and testbench



---
 rtl/wbu_commit_queue.sv | 120 ++++++++++++
 tb/tb_wbu_commit_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_commit_queue.sv
// rtl/wbu_commit_queue.sv - dual-way writeback commit queue releasing results in pID order
module wbu_commit_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        way0_valid_i,
    input  logic        way0_rdWriteEnable_i,
    input  logic [4:0]  way0_rdAddr_i,
    input  logic [63:0] way0_rdData_i,
    input  logic [1:0]  way0_pID_i,
    input  logic        way1_valid_i,
    input  logic        way1_rdWriteEnable_i,
    input  logic [4:0]  way1_rdAddr_i,
    input  logic [63:0] way1_rdData_i,
    input  logic [1:0]  way1_pID_i,
    output logic        way0_ready_o,
    output logic        way1_ready_o,
    output logic        way0_valid_o,
    output logic        way0_rdWriteEnable_o,
    output logic [4:0]  way0_rdAddr_o,
    output logic [63:0] way0_rdData_o,
    output logic [1:0]  way0_WBU_pID_o,
    input  logic        way0_ready_i,
    output logic        way1_valid_o,
    output logic        way1_rdWriteEnable_o,
    output logic [4:0]  way1_rdAddr_o,
    output logic [63:0] way1_rdData_o,
    output logic [1:0]  way1_WBU_pID_o,
    input  logic        way1_ready_i,
    output logic [1:0]  commitCount_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 72;

    // Entry layout: {we[71], addr[70:66], data[65:2], pid[1:0]}
    logic [EW-1:0] r_mem [2][DEPTH];
    logic [AW:0]   r_wr_ptr [2];
    logic [AW:0]   r_rd_ptr [2];
    logic [1:0]    r_seq;

    logic [EW-1:0] w_in_entry [2];
    logic [EW-1:0] w_head [2];
    logic [1:0]    w_in_valid;
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic          w_valid0;
    logic          w_valid1;
    logic          w_clear;
    logic [1:0]    w_seq_next1;
    logic [1:0]    w_count;

    assign w_in_valid    = {way1_valid_i, way0_valid_i};
    assign w_in_entry[0] = {way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i};
    assign w_in_entry[1] = {way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i};
    assign w_clear       = reset | flush_i;
    assign w_seq_next1   = r_seq + 2'd1;

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            w_empty[w] = (r_wr_ptr[w] == r_rd_ptr[w]);
            w_full[w]  = (r_wr_ptr[w][AW-1:0] == r_rd_ptr[w][AW-1:0]) &&
                         (r_wr_ptr[w][AW] != r_rd_ptr[w][AW]);
            w_head[w]  = r_mem[w][r_rd_ptr[w][AW-1:0]];
            w_push[w]  = w_in_valid[w] && !w_full[w];
        end
    end

    // way1 may pair with way0 only when way0 is certain to transfer this cycle
    assign w_valid0 = !reset && !w_empty[0] && (w_head[0][1:0] == r_seq);
    assign w_valid1 = !reset && !w_empty[1] &&
                      ((w_head[1][1:0] == r_seq) ||
                       ((w_head[1][1:0] == w_seq_next1) && w_valid0 && way0_ready_i));

    assign w_pop   = {w_valid1 && way1_ready_i, w_valid0 && way0_ready_i};
    assign w_count = {1'b0, w_pop[0]} + {1'b0, w_pop[1]};

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_seq <= 2'd0;
            for (int w = 0; w < 2; w++) begin
                r_wr_ptr[w] <= '0;
                r_rd_ptr[w] <= '0;
            end
        end else begin
            r_seq <= r_seq + w_count;
            for (int w = 0; w < 2; w++) begin
                if (w_push[w]) r_wr_ptr[w] <= r_wr_ptr[w] + (AW+1)'(1);
                if (w_pop[w])  r_rd_ptr[w] <= r_rd_ptr[w] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (!w_clear && w_push[w]) r_mem[w][r_wr_ptr[w][AW-1:0]] <= w_in_entry[w];
        end
    end

    assign way0_ready_o = !reset && !w_full[0];
    assign way1_ready_o = !reset && !w_full[1];

    assign way0_valid_o         = w_valid0;
    assign way0_rdWriteEnable_o = w_valid0 && w_head[0][71] && (w_head[0][70:66] != 5'd0);
    assign way0_rdAddr_o        = w_valid0 ? w_head[0][70:66] : 5'd0;
    assign way0_rdData_o        = w_valid0 ? w_head[0][65:2]  : 64'd0;
    assign way0_WBU_pID_o       = w_valid0 ? w_head[0][1:0]   : 2'd0;

    assign way1_valid_o         = w_valid1;
    assign way1_rdWriteEnable_o = w_valid1 && w_head[1][71] && (w_head[1][70:66] != 5'd0);
    assign way1_rdAddr_o        = w_valid1 ? w_head[1][70:66] : 5'd0;
    assign way1_rdData_o        = w_valid1 ? w_head[1][65:2]  : 64'd0;
    assign way1_WBU_pID_o       = w_valid1 ? w_head[1][1:0]   : 2'd0;

    // A commit coinciding with a flush does not retire anything
    assign commitCount_o = flush_i ? 2'd0 : w_count;
endmodule

// File: tb/tb_wbu_commit_queue.sv
// tb/tb_wbu_commit_queue.sv - randomized bench for wbu_commit_queue against a queue-based reference model
module tb_wbu_commit_queue;
    localparam int DEPTH = 2;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [63:0] d;
        logic [1:0]  p;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  v_i, we_i, rdy_i;
    logic [4:0]  a_i [2];
    logic [63:0] d_i [2];
    logic [1:0]  p_i [2];

    logic        rdyo0, rdyo1, vo0, vo1, weo0, weo1;
    logic [4:0]  ao0, ao1;
    logic [63:0] do0, do1;
    logic [1:0]  po0, po1, cnt;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [1:0]  m_seq = 2'd0;
    int          gen = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    wbu_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush_i(flush),
        .way0_valid_i(v_i[0]), .way0_rdWriteEnable_i(we_i[0]), .way0_rdAddr_i(a_i[0]),
        .way0_rdData_i(d_i[0]), .way0_pID_i(p_i[0]),
        .way1_valid_i(v_i[1]), .way1_rdWriteEnable_i(we_i[1]), .way1_rdAddr_i(a_i[1]),
        .way1_rdData_i(d_i[1]), .way1_pID_i(p_i[1]),
        .way0_ready_o(rdyo0), .way1_ready_o(rdyo1),
        .way0_valid_o(vo0), .way0_rdWriteEnable_o(weo0), .way0_rdAddr_o(ao0),
        .way0_rdData_o(do0), .way0_WBU_pID_o(po0), .way0_ready_i(rdy_i[0]),
        .way1_valid_o(vo1), .way1_rdWriteEnable_o(weo1), .way1_rdAddr_o(ao1),
        .way1_rdData_o(do1), .way1_WBU_pID_o(po1), .way1_ready_i(rdy_i[1]),
        .commitCount_o(cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        v_i  = 2'b00;
        we_i = 2'b00;
        for (int w = 0; w < 2; w++) begin
            a_i[w] = 5'd0;
            d_i[w] = 64'd0;
            p_i[w] = 2'd0;
        end
    endtask

    task automatic set_in(input int w, input logic [1:0] p, input logic [4:0] a,
                          input logic [63:0] d, input logic we);
        v_i[w]  = 1'b1;
        p_i[w]  = p;
        a_i[w]  = a;
        d_i[w]  = d;
        we_i[w] = we;
    endtask

    task automatic rnd_entry(input int w, input logic [1:0] p);
        logic [4:0] a;
        a = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
        set_in(w, p, a, {$urandom, $urandom}, 1'($urandom_range(1)));
    endtask

    // Offers the next item(s) of a global in-order stream; the second only when both ways have room
    task automatic drive_gen(input int pct);
        bit r0, r1;
        clr_in();
        r0 = !reset && (q0.size() < DEPTH);
        r1 = !reset && (q1.size() < DEPTH);
        if ($urandom_range(99) < pct) begin
            rnd_entry(gen % 2, 2'(gen));
            if (r0 && r1 && ($urandom_range(99) < pct))
                rnd_entry((gen + 1) % 2, 2'(gen + 1));
        end
    endtask

    task automatic step();
        ent_t       h0, h1;
        logic [1:0] s1;
        logic       e_v0, e_v1, x0, x1, a0, a1;
        @(negedge clk);
        h0 = '{default: '0};
        h1 = '{default: '0};
        if (q0.size() > 0) h0 = q0[0];
        if (q1.size() > 0) h1 = q1[0];
        s1   = m_seq + 2'd1;
        e_v0 = !reset && (q0.size() > 0) && (h0.p == m_seq);
        e_v1 = !reset && (q1.size() > 0) &&
               ((h1.p == m_seq) || ((h1.p == s1) && e_v0 && rdy_i[0]));
        x0 = e_v0 && rdy_i[0];
        x1 = e_v1 && rdy_i[1];
        chk("ready0", 64'(rdyo0), 64'(!reset && (q0.size() < DEPTH)));
        chk("ready1", 64'(rdyo1), 64'(!reset && (q1.size() < DEPTH)));
        chk("valid0", 64'(vo0), 64'(e_v0));
        chk("valid1", 64'(vo1), 64'(e_v1));
        chk("we0", 64'(weo0), 64'(e_v0 && h0.we && (h0.a != 5'd0)));
        chk("we1", 64'(weo1), 64'(e_v1 && h1.we && (h1.a != 5'd0)));
        chk("addr0", 64'(ao0), 64'(e_v0 ? h0.a : 5'd0));
        chk("addr1", 64'(ao1), 64'(e_v1 ? h1.a : 5'd0));
        chk("data0", do0, e_v0 ? h0.d : 64'd0);
        chk("data1", do1, e_v1 ? h1.d : 64'd0);
        chk("pid0", 64'(po0), 64'(e_v0 ? h0.p : 2'd0));
        chk("pid1", 64'(po1), 64'(e_v1 ? h1.p : 2'd0));
        chk("count", 64'(cnt), 64'(flush ? 2'd0 : (2'(x0) + 2'(x1))));
        @(posedge clk);
        if (reset || flush) begin
            q0.delete();
            q1.delete();
            m_seq = 2'd0;
            gen   = 0;
        end else begin
            a0 = v_i[0] && (q0.size() < DEPTH);
            a1 = v_i[1] && (q1.size() < DEPTH);
            if (x0) void'(q0.pop_front());
            if (x1) void'(q1.pop_front());
            if (a0) q0.push_back('{we_i[0], a_i[0], d_i[0], p_i[0]});
            if (a1) q1.push_back('{we_i[1], a_i[1], d_i[1], p_i[1]});
            m_seq = m_seq + 2'(x0) + 2'(x1);
            gen   = gen + int'(a0) + int'(a1);
        end
        #1;
    endtask

    task automatic reset_pulse();
        clr_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        clr_in();
        rdy_i = 2'b00;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_ready0", 64'(rdyo0), 64'd1);
        chk("rst_valid0", 64'(vo0), 64'd0);
        chk("rst_count", 64'(cnt), 64'd0);

        // Same-cycle pair commits together, then seq sits at 10
        set_in(0, 2'd0, 5'd5, 64'hA, 1'b1);
        set_in(1, 2'd1, 5'd6, 64'hB, 1'b1);
        rdy_i = 2'b11;
        step();
        clr_in();
        #1;
        chk("t1_v0", 64'(vo0), 64'd1);
        chk("t1_v1", 64'(vo1), 64'd1);
        chk("t1_cnt", 64'(cnt), 64'd2);
        step();
        set_in(0, 2'd2, 5'd3, 64'hC, 1'b1);
        set_in(1, 2'd3, 5'd4, 64'hD, 1'b1);
        step();
        clr_in();
        #1;
        chk("t1_seq_v1", 64'(vo1), 64'd1);
        step();

        // way1 cannot run ahead of an absent way0
        set_in(1, 2'd1, 5'd7, 64'h11, 1'b1);
        step();
        clr_in();
        repeat (3) begin
            #1;
            chk("t2_hold", 64'(vo1), 64'd0);
            step();
        end
        set_in(0, 2'd0, 5'd8, 64'h22, 1'b1);
        step();
        clr_in();
        #1;
        chk("t2_cnt", 64'(cnt), 64'd2);
        step();

        // Paired way1 valid follows way0_ready_i
        set_in(0, 2'd2, 5'd9, 64'h33, 1'b1);
        set_in(1, 2'd3, 5'd10, 64'h44, 1'b1);
        rdy_i = 2'b00;
        step();
        clr_in();
        rdy_i = 2'b10;
        #1;
        chk("t3_v0", 64'(vo0), 64'd1);
        chk("t3_v1", 64'(vo1), 64'd0);
        step();
        step();
        rdy_i = 2'b11;
        #1;
        chk("t3_cnt", 64'(cnt), 64'd2);
        step();

        // Stalled commits fill both FIFOs, then drain in order across the seq wrap
        reset_pulse();
        rdy_i = 2'b00;
        repeat (5) begin
            drive_gen(100);
            step();
        end
        clr_in();
        #1;
        chk("t4_full0", 64'(rdyo0), 64'd0);
        chk("t4_full1", 64'(rdyo1), 64'd0);
        rdy_i = 2'b11;
        repeat (6) begin
            drive_gen(100);
            step();
        end

        // rd 0 still commits but never writes
        reset_pulse();
        set_in(0, 2'd0, 5'd0, 64'h55, 1'b1);
        set_in(1, 2'd1, 5'd0, 64'h66, 1'b1);
        step();
        clr_in();
        #1;
        chk("t5_we0", 64'(weo0), 64'd0);
        chk("t5_v0", 64'(vo0), 64'd1);
        chk("t5_cnt", 64'(cnt), 64'd2);
        step();

        // Flush with 2+1 entries and a commit firing
        reset_pulse();
        rdy_i = 2'b00;
        set_in(0, 2'd0, 5'd1, 64'h77, 1'b1);
        set_in(1, 2'd1, 5'd2, 64'h88, 1'b1);
        step();
        clr_in();
        set_in(0, 2'd2, 5'd3, 64'h99, 1'b1);
        step();
        clr_in();
        rdy_i = 2'b11;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("t6_v0", 64'(vo0), 64'd0);
        chk("t6_v1", 64'(vo1), 64'd0);
        chk("t6_rdy0", 64'(rdyo0), 64'd1);
        set_in(0, 2'd0, 5'd4, 64'hAA, 1'b1);
        set_in(1, 2'd1, 5'd5, 64'hBB, 1'b1);
        step();
        clr_in();
        #1;
        chk("t6_seq0", 64'(cnt), 64'd2);
        step();

        // Randomized traffic with backpressure and occasional flushes
        reset_pulse();
        repeat (600) begin
            drive_gen(70);
            rdy_i = {1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0)};
            flush = ($urandom_range(63) == 0);
            step();
        end
        flush = 1'b0;
        clr_in();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
